// File: rtl/led_status_driver.sv
// LED status driver for the reaction-time tester: per-state LED patterns for N players,
// blink timebase, and a sequential fastest-player scan while in COMPARE.
module led_status_driver #(
   parameter int unsigned  NUM_PLAYERS    = 2,
   parameter int unsigned  TURN_W         = 3,
   parameter int unsigned  TIME_W         = 10,
   parameter int unsigned  LED_WIDTH      = 8,
   parameter int unsigned  CLK_HZ         = 12000000,
   parameter int unsigned  BLINK_HZ       = 2,
   parameter bit           LED_ACTIVE_LOW = 1'b0,
   localparam int unsigned PW             = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2:0]                    machine_state,
   input  logic [PW-1:0]                 cur_player,
   input  logic [NUM_PLAYERS*TURN_W-1:0] test_turn,
   input  logic [NUM_PLAYERS*TIME_W-1:0] avr_react_time,
   output logic [LED_WIDTH-1:0]          led,
   output logic [PW-1:0]                 winner,
   output logic                          winner_valid,
   output logic                          tie
);

   localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned POSW = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;

   typedef enum logic [2:0] {
      StIdle, StWait, StClrCnt1, StStart, StStorage, StClrCnt2, StAverage, StCompare
   } state_e;

   state_e                 w_state;
   logic [2:0]             r_state;
   logic [CW-1:0]          r_cnt, w_cnt_d;
   logic                   r_phase, w_phase_d;
   logic [POSW-1:0]        r_pos, w_pos_d;
   logic                   w_changed;
   logic [PW-1:0]          w_sel;
   logic [TURN_W-1:0]      w_turn;
   logic [TURN_W:0]        w_bar_len;
   logic [LED_WIDTH-1:0]   w_bar, w_pat, r_led;
   logic [PW-1:0]          r_idx, r_best_idx, r_winner, w_nbest_idx;
   logic [TIME_W-1:0]      r_best_val, w_nbest_val, w_avr_idx;
   logic                   r_scan, r_scan_tie, r_valid, r_tie, w_ntie, w_entry, w_last;

   assign w_state   = state_e'(machine_state);
   assign w_changed = (machine_state != r_state);

   // Blink timebase; a state change restarts it as if fresh out of reset
   always_comb begin
      w_cnt_d   = r_cnt + CW'(1);
      w_phase_d = r_phase;
      w_pos_d   = r_pos;
      if (w_changed) begin
         w_cnt_d   = '0;
         w_phase_d = 1'b1;
         w_pos_d   = '0;
      end else if (r_cnt == CW'(HALF - 1)) begin
         w_cnt_d   = '0;
         w_phase_d = ~r_phase;
         w_pos_d   = (r_pos == POSW'(LED_WIDTH - 1)) ? '0 : r_pos + POSW'(1);
      end
   end

   assign w_sel     = (32'(cur_player) < NUM_PLAYERS) ? cur_player : '0;
   assign w_turn    = test_turn[w_sel*TURN_W +: TURN_W];
   assign w_bar_len = {1'b0, w_turn} + (TURN_W+1)'(1);

   always_comb begin
      w_bar = '0;
      for (int i = 0; i < LED_WIDTH; i++) begin
         w_bar[i] = (32'(i) < 32'(w_bar_len));
      end
   end

   // One compare step of the winner scan
   assign w_avr_idx = avr_react_time[r_idx*TIME_W +: TIME_W];
   assign w_entry   = w_changed && (w_state == StCompare);
   assign w_last    = (32'(r_idx) == NUM_PLAYERS - 1);

   always_comb begin
      w_nbest_idx = r_best_idx;
      w_nbest_val = r_best_val;
      w_ntie      = r_scan_tie;
      if (w_avr_idx < r_best_val) begin
         w_nbest_idx = r_idx;
         w_nbest_val = w_avr_idx;
         w_ntie      = 1'b0;
      end else if (w_avr_idx == r_best_val) begin
         w_ntie = 1'b1;
      end
   end

   // Pattern uses next-state phase/position so it lines up with the registered led
   always_comb begin
      w_pat = '0;
      unique case (w_state)
         StIdle:               w_pat[w_pos_d] = 1'b1;
         StWait, StClrCnt1:    w_pat = {LED_WIDTH{w_phase_d}};
         StStart:              w_pat = '1;
         StStorage, StClrCnt2: w_pat = w_bar;
         StAverage:            w_pat = w_bar & {LED_WIDTH{w_phase_d}};
         StCompare: begin
            if (r_valid) begin
               if (r_tie) w_pat = {LED_WIDTH{w_phase_d}};
               else       w_pat[r_winner] = w_phase_d;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= 3'd0;
         r_cnt      <= '0;
         r_phase    <= 1'b1;
         r_pos      <= '0;
         r_led      <= {LED_WIDTH{LED_ACTIVE_LOW}};
         r_idx      <= '0;
         r_best_idx <= '0;
         r_best_val <= '0;
         r_winner   <= '0;
         r_scan     <= 1'b0;
         r_scan_tie <= 1'b0;
         r_valid    <= 1'b0;
         r_tie      <= 1'b0;
      end else begin
         r_state <= machine_state;
         r_cnt   <= w_cnt_d;
         r_phase <= w_phase_d;
         r_pos   <= w_pos_d;
         r_led   <= w_pat ^ {LED_WIDTH{LED_ACTIVE_LOW}};
         if (w_state != StCompare) begin
            r_scan  <= 1'b0;
            r_valid <= 1'b0;
            r_tie   <= 1'b0;
         end else if (w_entry) begin
            r_best_val <= avr_react_time[TIME_W-1:0];
            r_best_idx <= '0;
            r_scan_tie <= 1'b0;
            r_idx      <= PW'(1);
            r_scan     <= 1'b1;
            r_valid    <= 1'b0;
            r_tie      <= 1'b0;
         end else if (r_scan) begin
            r_best_val <= w_nbest_val;
            r_best_idx <= w_nbest_idx;
            r_scan_tie <= w_ntie;
            if (w_last) begin
               r_scan   <= 1'b0;
               r_valid  <= 1'b1;
               r_tie    <= w_ntie;
               r_winner <= w_nbest_idx;
            end else begin
               r_idx <= r_idx + PW'(1);
            end
         end
      end
   end

   assign led          = r_led;
   assign winner       = r_winner;
   assign winner_valid = r_valid;
   assign tie          = r_tie;

endmodule

// File: tb/tb_led_status_driver.sv
// Bench for led_status_driver: two instances (2 players/8 LEDs, 4 players/12 LEDs active-low)
// checked every cycle against an arithmetic model of the LED patterns and winner scan.
module tb_led_status_driver;

   localparam int HALF = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  st = 3'd0;
   logic [1:0]  cur = 2'd0;
   logic [5:0]  turn_a = '0;
   logic [11:0] turn_b = '0;
   logic [19:0] avr_a = '0;
   logic [39:0] avr_b = '0;

   logic [7:0]  led_a;
   logic        win_a, valid_a, tie_a;
   logic [11:0] led_b;
   logic [1:0]  win_b;
   logic        valid_b, tie_b;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: n = edges since last state change, m = edges since COMPARE entry
   int         n = 0;
   int         m = 0;
   logic [2:0] prev_st = 3'd0;
   bit         ev_a = 0, et_a = 0, ev_b = 0, et_b = 0;
   int         ew_a = 0, ew_b = 0;

   led_status_driver #(
      .NUM_PLAYERS(2), .LED_WIDTH(8), .CLK_HZ(16), .BLINK_HZ(2), .LED_ACTIVE_LOW(1'b0)
   ) dut_a (
      .clk(clk), .rst(rst), .machine_state(st), .cur_player(cur[0]), .test_turn(turn_a),
      .avr_react_time(avr_a), .led(led_a), .winner(win_a), .winner_valid(valid_a), .tie(tie_a)
   );

   led_status_driver #(
      .NUM_PLAYERS(4), .LED_WIDTH(12), .CLK_HZ(16), .BLINK_HZ(2), .LED_ACTIVE_LOW(1'b1)
   ) dut_b (
      .clk(clk), .rst(rst), .machine_state(st), .cur_player(cur), .test_turn(turn_b),
      .avr_react_time(avr_b), .led(led_b), .winner(win_b), .winner_valid(valid_b), .tie(tie_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_led(input int np, input int lw, input bit al,
                                           input logic [2:0] s, input int c,
                                           input logic [11:0] turns, input int nn,
                                           input bit vld, input bit ti, input int win);
      int blk, pos, sel, t, k;
      bit ph;
      logic [15:0] all, bar, p;
      blk = nn / HALF;
      ph  = (blk % 2) == 0;
      pos = blk % lw;
      all = 16'((1 << lw) - 1);
      sel = (c < np) ? c : 0;
      t   = int'((turns >> (sel * 3)) & 12'h7);
      k   = (t + 1 < lw) ? t + 1 : lw;
      bar = 16'((1 << k) - 1);
      case (s)
         3'd0:       p = 16'(1 << pos);
         3'd1, 3'd2: p = ph ? all : 16'h0;
         3'd3:       p = all;
         3'd4, 3'd5: p = bar;
         3'd6:       p = ph ? bar : 16'h0;
         default:    p = (!vld || !ph) ? 16'h0 : (ti ? all : 16'(1 << win));
      endcase
      return al ? (p ^ all) : p;
   endfunction

   // Winner = lowest index holding the minimum; tie = minimum held more than once
   function automatic void ref_winner(input logic [39:0] avr, input int np,
                                      output int win, output bit ti);
      int mn, cnt;
      mn = 1 << 30;
      cnt = 0;
      win = 0;
      for (int i = 0; i < np; i++) if (int'(avr[i*10 +: 10]) < mn) mn = int'(avr[i*10 +: 10]);
      for (int i = np - 1; i >= 0; i--) begin
         if (int'(avr[i*10 +: 10]) == mn) begin
            win = i;
            cnt++;
         end
      end
      ti = cnt > 1;
   endfunction

   task automatic step();
      logic [15:0] exp_a, exp_b;
      @(posedge clk);
      if (st != prev_st) n = 0; else n++;
      if (st == 3'd7 && prev_st == 3'd7) m++; else m = 0;
      exp_a = exp_led(2, 8, 1'b0, st, int'(cur[0]), {6'h0, turn_a}, n, ev_a, et_a, ew_a);
      exp_b = exp_led(4, 12, 1'b1, st, int'(cur), turn_b, n, ev_b, et_b, ew_b);
      if (st != 3'd7 || m < 1) begin
         ev_a = 0; et_a = 0;
      end else if (m == 1) begin
         ev_a = 1; ref_winner({20'h0, avr_a}, 2, ew_a, et_a);
      end
      if (st != 3'd7 || m < 3) begin
         ev_b = 0; et_b = 0;
      end else if (m == 3) begin
         ev_b = 1; ref_winner(avr_b, 4, ew_b, et_b);
      end
      prev_st = st;
      #1;
      check("led_a", 16'(led_a), exp_a);
      check("led_b", 16'(led_b), exp_b);
      check("valid_a", 16'(valid_a), 16'(ev_a));
      check("valid_b", 16'(valid_b), 16'(ev_b));
      check("tie_a", 16'(tie_a), 16'(et_a));
      check("tie_b", 16'(tie_b), 16'(et_b));
      if (ev_a) check("winner_a", 16'(win_a), 16'(ew_a));
      if (ev_b) check("winner_b", 16'(win_b), 16'(ew_b));
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      n = 0; m = 0; prev_st = 3'd0;
      ev_a = 0; et_a = 0; ew_a = 0; ev_b = 0; et_b = 0; ew_b = 0;
      #1;
      check("rst_led_a", 16'(led_a), 16'h000);
      check("rst_led_b", 16'(led_b), 16'hFFF);
      check("rst_valid", {14'h0, valid_a, valid_b}, 16'h0);
      check("rst_tie", {14'h0, tie_a, tie_b}, 16'h0);
      check("rst_winner", {13'h0, win_a, win_b}, 16'h0);
      repeat (hold) @(posedge clk);
      #1;
      check("rst_hold_led_a", 16'(led_a), 16'h000);
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] ns;
      #2;
      do_reset(2);

      // IDLE chaser from reset
      step();
      check("idle_first", 16'(led_a), 16'h01);
      repeat (3) step();
      check("idle_second", 16'(led_a), 16'h02);
      repeat (34) step();

      // WAIT blink, then START mid-phase
      st = 3'd1;
      step();
      check("wait_on", 16'(led_a), 16'hFF);
      repeat (5) step();
      check("wait_off", 16'(led_a), 16'h00);
      st = 3'd3;
      step();
      check("start_steady", 16'(led_a), 16'hFF);
      repeat (3) step();

      // Progress bar for player 1 (turn 2), then blinking in AVERAGE
      st = 3'd4; cur = 2'd1; turn_a = {3'd2, 3'd5}; turn_b = {3'd0, 3'd1, 3'd6, 3'd3};
      step();
      check("storage_bar", 16'(led_a), 16'h07);
      st = 3'd6;
      step();
      repeat (4) step();
      check("average_off", 16'(led_a), 16'h00);
      repeat (4) step();

      // COMPARE: clear winner for A, tie for B
      avr_a = {10'd999, 10'd499};
      avr_b = {10'd300, 10'd120, 10'd120, 10'd450};
      st = 3'd7;
      repeat (2) step();
      check("cmp_valid_a", 16'(valid_a), 16'h1);
      check("cmp_win_a", 16'(win_a), 16'h0);
      check("cmp_notie_a", 16'(tie_a), 16'h0);
      step();
      check("cmp_led_a", 16'(led_a), 16'h01);
      step();
      check("cmp_valid_b", 16'(valid_b), 16'h1);
      check("cmp_win_b", 16'(win_b), 16'h1);
      check("cmp_tie_b", 16'(tie_b), 16'h1);
      repeat (5) step();
      check("cmp_led_b_on", 16'(led_b), 16'h000);
      repeat (6) step();

      // Tie on A, then a reset while B is mid-scan
      st = 3'd0;
      step();
      check("leave_valid_a", 16'(valid_a), 16'h0);
      avr_a = {10'd499, 10'd499};
      st = 3'd7;
      repeat (2) step();
      check("cmp_tie_a", 16'(tie_a), 16'h1);
      repeat (8) step();
      st = 3'd0;
      step();
      st = 3'd7;
      repeat (2) step();
      do_reset(1);
      repeat (3) step();

      // Randomized state sequences
      for (int it = 0; it < 250; it++) begin
         ns = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
         if (!(ns == 3'd7 && prev_st == 3'd7)) begin
            avr_a = {10'($urandom_range(0, 3) * 100), 10'($urandom_range(0, 3) * 100)};
            for (int p = 0; p < 4; p++) avr_b[p*10 +: 10] = 10'($urandom_range(0, 3) * 100);
         end
         st     = ns;
         cur    = 2'($urandom);
         turn_a = 6'($urandom);
         turn_b = 12'($urandom);
         repeat ($urandom_range(1, 12)) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
